decimal_to_hexa: RTL and testbench
==================================

DECIMAL_TO_HEXA -- requirements
Module: decimal_to_hexa

Interface
REQ-001 SHALL have parameter WIDTH, default 16, giving the result width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port digit  input  4  BCD decimal digit, most significant digit first.
REQ-005 SHALL have port digit_valid  input  1  digit (and digit_last) is presented.
REQ-006 SHALL have port digit_last  input  1  current digit is the final digit of the number.
REQ-007 SHALL have port digit_ready  output  1  block accepts a digit this cycle.
REQ-008 SHALL have port binary  output  WIDTH  converted value; its 4-bit nibbles are the hex digits.
REQ-009 SHALL have port ndigits  output  4  count of digits accepted for the number, saturating at 15.
REQ-010 SHALL have port overflow  output  1  value exceeded 2^WIDTH-1.
REQ-011 SHALL have port error  output  1  at least one digit was greater than 9.
REQ-012 SHALL have port result_valid  output  1  binary/ndigits/overflow/error hold a finished result.
REQ-013 SHALL have port result_ready  input  1  consumer accepts the result.

Function
REQ-014 SHALL implement exactly two states: ACCUM (digit_ready=1, result_valid=0) and DONE (digit_ready=0, result_valid=1).
REQ-015 SHALL accept a digit only on a cycle with digit_valid=1 and digit_ready=1; digit inputs on other cycles SHALL be ignored.
REQ-016 SHALL, for each accepted digit d<=9, update acc <= acc*10 + d, with the product formed as (acc<<3)+(acc<<1) at WIDTH+4 bits.
REQ-017 SHALL, for an accepted digit d>9, set the sticky error flag and leave acc unchanged; the digit SHALL still count in ndigits.
REQ-018 SHALL, when acc*10+d exceeds 2^WIDTH-1, set the sticky overflow flag and saturate acc to 2^WIDTH-1; later digits SHALL keep acc saturated.
REQ-019 SHALL transition ACCUM->DONE on the cycle an accepted digit has digit_last=1, with result_valid=1 on the next cycle (latency 1 cycle after the last digit).
REQ-020 SHALL hold binary, ndigits, overflow and error stable in DONE until result_ready=1.
REQ-021 SHALL, on a cycle in DONE with result_ready=1, return to ACCUM and clear acc, ndigits, overflow and error to 0 on the next cycle.
REQ-022 SHALL drive binary=acc, ndigits, overflow and error continuously in both states; the values are qualified only by result_valid.
REQ-023 SHALL treat a single accepted digit with digit_last=1 as a complete number (ndigits=1).
REQ-024 SHALL leave result_ready without effect in ACCUM.

Reset
REQ-025 SHALL, when rst=1 at a rising edge, enter ACCUM and set acc=0, ndigits=0, overflow=0, error=0, result_valid=0 and digit_ready=1, regardless of state or of a partially entered number.
REQ-026 SHALL give rst priority over every digit and result handshake in the same cycle.

Verification
REQ-027 SHALL be checked with digits 2,5,5 (last on 5) and result_ready=1: binary=16'h00FF, ndigits=3, overflow=0, error=0, and result_valid high for exactly 1 cycle.
REQ-028 SHALL be checked with digits 6,5,5,3,6 (WIDTH=16): overflow=1 and binary=16'hFFFF; with 6,5,5,3,5: binary=16'hFFFF and overflow=0.
REQ-029 SHALL be checked with digits 1,A,2 (last on 2): error=1, binary=16'h000C, ndigits=3.
REQ-030 SHALL be checked with a result of 4,0,9,5 and result_ready held low 5 cycles: binary=16'h0FFF stable, digit_ready=0, and a digit_valid pulse during DONE ignored; the next number 7 gives binary=16'h0007.
REQ-031 SHALL be checked with rst asserted after digits 9,9 and before the last digit: outputs cleared per REQ-025; the next number 3 (last) gives binary=16'h0003, ndigits=1.
REQ-032 SHALL be checked with back-to-back digits on consecutive cycles and gaps in digit_valid: identical results (for example 1,0,0 -> 16'h0064).

Source files
------------

// File: rtl/decimal_to_hexa.sv
// Streams BCD digits (most significant first) into a binary accumulator. When the
// digit flagged as last is accepted, the result is held until the consumer takes it.
//
// Parameters:
//   WIDTH        result width in bits
// Ports:
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   digit        BCD digit in
//   digit_valid  digit/digit_last are presented
//   digit_last   current digit ends the number
//   digit_ready  block accepts a digit this cycle (ACCUM state)
//   binary       accumulated value (hex digits are its nibbles)
//   ndigits      digits accepted for this number, saturating at 15
//   overflow     sticky: value exceeded 2^WIDTH-1 (binary saturated)
//   error        sticky: a digit greater than 9 was accepted
//   result_valid outputs hold a finished result (DONE state)
//   result_ready consumer accepts the result
module decimal_to_hexa #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       digit,
  input  logic             digit_valid,
  input  logic             digit_last,
  output logic             digit_ready,
  output logic [WIDTH-1:0] binary,
  output logic [3:0]       ndigits,
  output logic             overflow,
  output logic             error,
  output logic             result_valid,
  input  logic             result_ready
);

  localparam int unsigned ProdW = WIDTH + 4;
  localparam logic [WIDTH-1:0] AccMax = '1;

  typedef enum logic [0:0] {StAccum, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [3:0]       ndigits_q, ndigits_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;

  logic [ProdW-1:0] acc_ext;
  logic [ProdW-1:0] sum;

  // acc*10 + d never exceeds WIDTH+4 bits, so the compare against AccMax is exact.
  assign acc_ext = {4'b0000, acc_q};
  assign sum     = (acc_ext << 3) + (acc_ext << 1) + {{WIDTH{1'b0}}, digit};

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    ndigits_d    = ndigits_q;
    ovf_d        = ovf_q;
    err_d        = err_q;
    digit_ready  = (state_q == StAccum);
    result_valid = (state_q == StDone);

    unique case (state_q)
      StAccum: begin
        if (digit_valid) begin
          ndigits_d = (ndigits_q == 4'hF) ? 4'hF : ndigits_q + 4'd1;
          if (digit > 4'd9) begin
            // Non-BCD digit still counts but leaves the value alone.
            err_d = 1'b1;
          end else if (sum > {4'b0000, AccMax}) begin
            ovf_d = 1'b1;
            acc_d = AccMax;
          end else begin
            acc_d = sum[WIDTH-1:0];
          end
          if (digit_last) state_d = StDone;
        end
      end
      StDone: begin
        if (result_ready) begin
          state_d   = StAccum;
          acc_d     = '0;
          ndigits_d = 4'd0;
          ovf_d     = 1'b0;
          err_d     = 1'b0;
        end
      end
      default: state_d = StAccum;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StAccum;
      acc_q     <= '0;
      ndigits_q <= 4'd0;
      ovf_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      ndigits_q <= ndigits_d;
      ovf_q     <= ovf_d;
      err_q     <= err_d;
    end
  end

  assign binary   = acc_q;
  assign ndigits  = ndigits_q;
  assign overflow = ovf_q;
  assign error    = err_q;

endmodule

// File: tb/tb_decimal_to_hexa.sv
module tb_decimal_to_hexa;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   digit;
  logic         digit_valid;
  logic         digit_last;
  logic         digit_ready;
  logic [W-1:0] binary;
  logic [3:0]   ndigits;
  logic         overflow;
  logic         error;
  logic         result_valid;
  logic         result_ready;

  decimal_to_hexa #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .digit        (digit),
    .digit_valid  (digit_valid),
    .digit_last   (digit_last),
    .digit_ready  (digit_ready),
    .binary       (binary),
    .ndigits      (ndigits),
    .overflow     (overflow),
    .error        (error),
    .result_valid (result_valid),
    .result_ready (result_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] bin;
    logic [3:0]   nd;
    logic         ovf;
    logic         err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   ready_mode = 1;  // 0: random, 1: always high, 2: always low

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: decimal value built digit by digit with plain integer arithmetic.
  function automatic exp_t model(input int unsigned d[$]);
    exp_t   e;
    longint v = 0;
    longint maxv = (longint'(1) << W) - 1;
    e.ovf = 1'b0;
    e.err = 1'b0;
    foreach (d[i]) begin
      if (d[i] > 9) e.err = 1'b1;
      else begin
        v = v * 10 + longint'(d[i]);
        if (v > maxv) begin
          e.ovf = 1'b1;
          v = maxv;
        end
      end
    end
    e.bin = v[W-1:0];
    e.nd  = (d.size() > 15) ? 4'd15 : 4'(d.size());
    return e;
  endfunction

  // Result-ready driver.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       result_ready = 1'($urandom_range(0, 1));
      1:       result_ready = 1'b1;
      default: result_ready = 1'b0;
    endcase
  end

  // Monitor: scoreboard pop on result handshake, plus hold-stability and state checks.
  exp_t prev;
  bit   held = 0;
  always @(negedge clk) begin
    if (rst) begin
      held = 0;
    end else begin
      chk("ready_vs_valid", digit_ready, !result_valid);
      if (result_valid) begin
        if (held) begin
          chk("hold_binary", binary, prev.bin);
          chk("hold_ndigits", ndigits, prev.nd);
          chk("hold_flags", {overflow, error}, {prev.ovf, prev.err});
        end
        prev.bin = binary;
        prev.nd  = ndigits;
        prev.ovf = overflow;
        prev.err = error;
        held = !result_ready;
        if (result_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_result", result_valid, 1'b0);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("sb_binary", binary, e.bin);
            chk("sb_ndigits", ndigits, e.nd);
            chk("sb_overflow", overflow, e.ovf);
            chk("sb_error", error, e.err);
          end
        end
      end else begin
        held = 0;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the digit was accepted.
  task automatic drive_digit(input logic [3:0] d, input logic last);
    int n = 0;
    digit_valid = 1'b1;
    digit       = d;
    digit_last  = last;
    @(negedge clk);
    while (!digit_ready && n < 300) begin
      n++;
      @(negedge clk);
    end
    if (!digit_ready) chk("digit_ready_timeout", digit_ready, 1'b1);
    @(posedge clk);
    #1;
    digit_valid = 1'b0;
    digit       = 4'($urandom);
    digit_last  = 1'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_num(input int unsigned d[$], input bit gaps);
    exp_q.push_back(model(d));
    foreach (d[i]) begin
      if (gaps) idle($urandom_range(0, 3));
      drive_digit(4'(d[i]), i == d.size() - 1);
    end
  endtask

  initial begin
    int unsigned num[$];
    int n;
    rst = 1'b1;
    digit = 4'd0;
    digit_valid = 1'b0;
    digit_last = 1'b0;
    result_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_binary", binary, 16'h0000);
    chk("reset_ndigits", ndigits, 4'd0);
    chk("reset_flags", {overflow, error}, 2'b00);
    chk("reset_valid", result_valid, 1'b0);
    chk("reset_ready", digit_ready, 1'b1);
    @(posedge clk);
    #1;

    // 2,5,5 -> 0x00FF, result valid for exactly one cycle when consumed immediately.
    ready_mode = 1;
    send_num('{2, 5, 5}, 0);
    @(negedge clk);
    chk("d255_valid", result_valid, 1'b1);
    chk("d255_binary", binary, 16'h00FF);
    chk("d255_ndigits", ndigits, 4'd3);
    @(negedge clk);
    chk("d255_valid_one_cycle", result_valid, 1'b0);
    idle(1);

    // Overflow boundary, error digit, back-to-back vs gapped.
    send_num('{6, 5, 5, 3, 6}, 0);
    send_num('{6, 5, 5, 3, 5}, 1);
    send_num('{1, 10, 2}, 0);
    send_num('{1, 0, 0}, 0);
    send_num('{1, 0, 0}, 1);
    send_num('{7, 0, 0, 0, 0, 0, 0, 0}, 1);

    // 4095 held for 5 cycles; a digit pulse during DONE must be ignored.
    ready_mode = 2;
    idle(2);
    send_num('{4, 0, 9, 5}, 0);
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin
        digit_valid = 1'b1;
        digit       = 4'd7;
        digit_last  = 1'b1;
      end
      @(negedge clk);
      chk("hold_fff_binary", binary, 16'h0FFF);
      chk("hold_fff_dready", digit_ready, 1'b0);
      @(posedge clk);
      #1;
      digit_valid = 1'b0;
    end
    ready_mode = 1;
    send_num('{7}, 0);
    @(negedge clk);
    chk("after_hold_binary", binary, 16'h0007);
    @(posedge clk);
    #1;

    // Reset mid-number, with a competing digit on the reset cycle.
    drive_digit(4'd9, 1'b0);
    drive_digit(4'd9, 1'b0);
    rst = 1'b1;
    digit_valid = 1'b1;
    digit = 4'd5;
    digit_last = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    digit_valid = 1'b0;
    @(negedge clk);
    chk("midrst_binary", binary, 16'h0000);
    chk("midrst_ndigits", ndigits, 4'd0);
    chk("midrst_flags", {overflow, error}, 2'b00);
    chk("midrst_valid", result_valid, 1'b0);
    chk("midrst_ready", digit_ready, 1'b1);
    @(posedge clk);
    #1;
    send_num('{3}, 0);
    @(negedge clk);
    chk("after_rst_binary", binary, 16'h0003);
    chk("after_rst_ndigits", ndigits, 4'd1);
    @(posedge clk);
    #1;

    // Random numbers with random gaps and random consumer backpressure.
    ready_mode = 0;
    for (int k = 0; k < 40; k++) begin
      num.delete();
      n = (k == 5) ? 17 : int'($urandom_range(1, 7));
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 9) == 0) num.push_back($urandom_range(10, 15));
        else num.push_back($urandom_range(0, 9));
      end
      send_num(num, 1'($urandom_range(0, 1)));
    end

    ready_mode = 1;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      n++;
      @(posedge clk);
    end
    chk("scoreboard_drain", exp_q.size(), 0);
    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
